// File: rtl/sample_frame_packer.sv
// Packs the I and U decimated samples into a 6-byte frame for the UART:
// SYNC, I_hi, I_lo, U_hi, U_lo, CHK.
//
// Parameters:
//   WIDTH     - filtered sample width (9..16), zero-extended to 16 bits.
//   SYNC_BYTE - first byte of every frame.
// Ports:
//   clk, rst         - system clock, asynchronous active-high reset
//   word_clk         - decimation strobe, asynchronous to clk
//   data_i, data_u   - filtered I/U words, stable >= 4 clk after word_clk rises
//   tx_ready         - UART accepts the byte on this edge
//   tx_valid/tx_data - byte handshake towards the UART
//   busy             - frame in progress
//   overrun          - sticky, a sample arrived while a frame was in progress
module sample_frame_packer #(
  parameter int          WIDTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             word_clk,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] data_u,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_IH,
    S_IL,
    S_UH,
    S_UL,
    S_CK
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  wsync_q;
  logic        hist_q;
  logic [1:0]  fill_q;
  logic        arm_q, arm_d;
  logic [15:0] i_q, u_q;
  logic [7:0]  chk_q;
  logic [7:0]  txd_q, txd_d;
  logic        vld_q;
  logic        ovr_q, ovr_d;
  logic        cap;
  logic        accept;
  logic        sync_w;
  logic        edge_w;
  logic [15:0] ext_i, ext_u;
  logic [7:0]  chk_new;

  always_comb begin
    ext_i = '0;
    ext_u = '0;
    ext_i[WIDTH-1:0] = data_i;
    ext_u[WIDTH-1:0] = data_u;
  end

  assign chk_new = ext_i[15:8] ^ ext_i[7:0]
                 ^ ext_u[15:8] ^ ext_u[7:0];

  assign sync_w = wsync_q[1];
  assign edge_w = arm_q & sync_w & ~hist_q;
  assign accept = (state_q != S_IDLE) & tx_ready;

  // The synchroniser output only reflects word_clk once the chain has
  // refilled after reset; arming before that would let a word_clk held
  // high across reset release look like a fresh rising edge.
  assign arm_d = arm_q | (fill_q[1] & ~sync_w);

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    cap     = 1'b0;
    ovr_d   = ovr_q | (edge_w & (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: if (edge_w) begin
        state_d = S_SYNC;
        txd_d   = SYNC_BYTE;
        cap     = 1'b1;
      end
      S_SYNC: if (accept) begin
        state_d = S_IH;
        txd_d   = i_q[15:8];
      end
      S_IH: if (accept) begin
        state_d = S_IL;
        txd_d   = i_q[7:0];
      end
      S_IL: if (accept) begin
        state_d = S_UH;
        txd_d   = u_q[15:8];
      end
      S_UH: if (accept) begin
        state_d = S_UL;
        txd_d   = u_q[7:0];
      end
      S_UL: if (accept) begin
        state_d = S_CK;
        txd_d   = chk_q;
      end
      S_CK: if (accept) begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wsync_q <= '0;
      hist_q  <= 1'b0;
      fill_q  <= '0;
      arm_q   <= 1'b0;
      i_q     <= '0;
      u_q     <= '0;
      chk_q   <= '0;
      txd_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wsync_q <= {wsync_q[0], word_clk};
      hist_q  <= sync_w;
      fill_q  <= {fill_q[0], 1'b1};
      arm_q   <= arm_d;
      txd_q   <= txd_d;
      vld_q   <= (state_d != S_IDLE);
      ovr_q   <= ovr_d;
      if (cap) begin
        i_q   <= ext_i;
        u_q   <= ext_u;
        chk_q <= chk_new;
      end
    end
  end

  assign tx_valid = vld_q;
  assign busy     = vld_q;
  assign tx_data  = txd_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_sample_frame_packer.sv
// Bench for sample_frame_packer: directed scenarios plus randomized frames
// checked against a byte-level frame model (WIDTH=16 and WIDTH=12 instances).
module tb_sample_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        word_clk = 1'b0;
  logic        tx_ready = 1'b0;
  logic [15:0] di16 = '0, du16 = '0;
  logic [11:0] di12 = '0, du12 = '0;
  logic        v16, b16, o16, v12, b12, o12;
  logic [7:0]  d16, d12;

  int tests = 0;
  int fails = 0;

  logic [7:0] got16[$];
  logic [7:0] got12[$];

  always #5 clk = ~clk;

  sample_frame_packer #(.WIDTH(16), .SYNC_BYTE(8'hA5)) dut16 (
    .clk(clk), .rst(rst), .word_clk(word_clk),
    .data_i(di16), .data_u(du16), .tx_ready(tx_ready),
    .tx_valid(v16), .tx_data(d16), .busy(b16), .overrun(o16)
  );

  sample_frame_packer #(.WIDTH(12), .SYNC_BYTE(8'hA5)) dut12 (
    .clk(clk), .rst(rst), .word_clk(word_clk),
    .data_i(di12), .data_u(du12), .tx_ready(tx_ready),
    .tx_valid(v12), .tx_data(d12), .busy(b12), .overrun(o12)
  );

  // Byte collection and hold-stability checking on the handshake.
  logic       hold_p = 1'b0;
  logic [7:0] hold_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        tests++;
        if (v16 !== 1'b1 || d16 !== hold_d) begin
          fails++;
          $display("FAIL hold_stable got v=%b d=%h exp v=1 d=%h",
                   v16, d16, hold_d);
        end
      end
      if (v16 && tx_ready) got16.push_back(d16);
      if (v12 && tx_ready) got12.push_back(d12);
      hold_p = v16 && !tx_ready;
      hold_d = d16;
    end
  end

  // Frame model: sync, big-endian I, big-endian U, xor of the data bytes.
  function automatic void model(input int i, input int u,
                                output logic [7:0] f[6]);
    f[0] = 8'hA5;
    f[1] = 8'((i / 256) % 256);
    f[2] = 8'(i % 256);
    f[3] = 8'((u / 256) % 256);
    f[4] = 8'(u % 256);
    f[5] = f[1] ^ f[2] ^ f[3] ^ f[4];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse();
    @(posedge clk);
    #1 word_clk = 1'b1;
    repeat (6) @(posedge clk);
    #1 word_clk = 1'b0;
  endtask

  task automatic accept_one();
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (v16) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (got16.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    word_clk = 1'b0;
    tx_ready = 1'b0;
    repeat (3) tick();
    tests++;
    if ({v16, d16, b16, o16} !== 10'b0 || {v12, d12, b12, o12} !== 10'b0) begin
      fails++;
      $display("FAIL reset got %b %h %b %b / %b %h %b %b exp all zero",
               v16, d16, b16, o16, v12, d12, b12, o12);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();
    tests++;
    if (v16 !== 1'b0 || b16 !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got v=%b b=%b exp 0 0", v16, b16);
    end
  endtask

  task automatic test_basic();
    logic [7:0] e[6] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    int  n;
    bit  ok;
    got16.delete();
    di16 = 16'h1234;
    du16 = 16'hABCD;
    tx_ready = 1'b1;
    @(posedge clk);
    #1 word_clk = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (v16) break;
    end
    tests++;
    if (n < 3 || n > 4) begin
      fails++;
      $display("FAIL latency got %0d cycles exp 3..4", n);
    end
    repeat (4) @(posedge clk);
    #1 word_clk = 1'b0;
    wait_bytes(6, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_timeout got %0d bytes exp 6", got16.size());
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (got16[k] !== e[k]) begin
        fails++;
        $display("FAIL basic_byte%0d got %h exp %h", k, got16[k], e[k]);
      end
    end
    tick();
    tests++;
    if (v16 !== 1'b0 || b16 !== 1'b0 || d16 !== 8'h40) begin
      fails++;
      $display("FAIL basic_end got v=%b b=%b d=%h exp 0 0 40", v16, b16, d16);
    end
    repeat (10) tick();
    tests++;
    if (got16.size() != 6 || v16 !== 1'b0) begin
      fails++;
      $display("FAIL basic_extra got %0d bytes v=%b exp 6 0", got16.size(), v16);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e[6] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    bit ok;
    int bad;
    got16.delete();
    tx_ready = 1'b0;
    pulse();
    wait_valid(ok);
    accept_one();
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (v16 !== 1'b1 || d16 !== 8'h12) bad++;
    end
    tests++;
    if (!ok || bad != 0) begin
      fails++;
      $display("FAIL bp_hold got %0d bad cycles (v=%b d=%h) exp 0", bad, v16, d16);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_bytes(6, ok);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (got16[k] !== e[k]) begin
        fails++;
        $display("FAIL bp_byte%0d got %h exp %h", k, got16[k], e[k]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_overrun();
    logic [7:0] e[6];
    bit ok;
    bit seen;
    got16.delete();
    tx_ready = 1'b0;
    di16 = 16'h5A3C;
    du16 = 16'h0F81;
    model(32'h5A3C, 32'h0F81, e);
    tests++;
    if (o16 !== 1'b0) begin
      fails++;
      $display("FAIL ovr_pre got %b exp 0", o16);
    end
    pulse();
    wait_valid(ok);
    repeat (3) accept_one();
    di16 = 16'hFFFF;
    du16 = 16'h1111;
    pulse();
    repeat (3) tick();
    tests++;
    if (o16 !== 1'b1 || v16 !== 1'b1 || d16 !== e[3]) begin
      fails++;
      $display("FAIL ovr_flag got o=%b v=%b d=%h exp 1 1 %h", o16, v16, d16, e[3]);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_bytes(6, ok);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (got16[k] !== e[k]) begin
        fails++;
        $display("FAIL ovr_byte%0d got %h exp %h", k, got16[k], e[k]);
      end
    end
    seen = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 30; k++) begin
      tick();
      if (v16) seen = 1'b1;
    end
    tests++;
    if (seen || got16.size() != 6 || o16 !== 1'b1) begin
      fails++;
      $display("FAIL ovr_nosecond got seen=%b n=%0d o=%b exp 0 6 1",
               seen, got16.size(), o16);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] e[6];
    bit ok;
    bit seen;
    tx_ready = 1'b0;
    di16 = 16'hC0DE;
    du16 = 16'h7E57;
    model(32'hC0DE, 32'h7E57, e);
    pulse();
    wait_valid(ok);
    repeat (3) accept_one();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++;
    if (v16 !== 1'b0 || d16 !== 8'h00 || o16 !== 1'b0 || b16 !== 1'b0) begin
      fails++;
      $display("FAIL async_rst got v=%b d=%h o=%b b=%b exp 0 00 0 0",
               v16, d16, o16, b16);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tx_ready = 1'b1;
    got16.delete();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (v16) seen = 1'b1;
    end
    tests++;
    if (seen || got16.size() != 0) begin
      fails++;
      $display("FAIL rst_noresume got seen=%b n=%0d exp 0 0", seen, got16.size());
    end
    pulse();
    wait_bytes(6, ok);
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (got16[k] !== e[k]) begin
        fails++;
        $display("FAIL rst_byte%0d got %h exp %h", k, got16[k], e[k]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_arm();
    logic [7:0] e[6];
    bit ok;
    bit seen;
    di16 = 16'h0001;
    du16 = 16'hFF00;
    model(32'h0001, 32'hFF00, e);
    tx_ready = 1'b1;
    rst = 1'b1;
    word_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got16.delete();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (v16) seen = 1'b1;
    end
    tests++;
    if (seen || got16.size() != 0) begin
      fails++;
      $display("FAIL arm_spurious got seen=%b n=%0d exp 0 0", seen, got16.size());
    end
    word_clk = 1'b0;
    repeat (4) @(posedge clk);
    pulse();
    wait_bytes(6, ok);
    repeat (20) tick();
    tests++;
    if (!ok || got16.size() != 6) begin
      fails++;
      $display("FAIL arm_count got %0d bytes exp 6", got16.size());
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (got16[k] !== e[k]) begin
        fails++;
        $display("FAIL arm_byte%0d got %h exp %h", k, got16[k], e[k]);
      end
    end
  endtask

  task automatic test_width12();
    logic [7:0] e[6] = '{8'hA5, 8'h0F, 8'hFF, 8'h08, 8'h00, 8'hF8};
    bit ok;
    got12.delete();
    got16.delete();
    di12 = 12'hFFF;
    du12 = 12'h800;
    tx_ready = 1'b1;
    pulse();
    wait_bytes(6, ok);
    repeat (3) tick();
    tests++;
    if (got12.size() != 6) begin
      fails++;
      $display("FAIL w12_count got %0d exp 6", got12.size());
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (got12[k] !== e[k]) begin
        fails++;
        $display("FAIL w12_byte%0d got %h exp %h", k, got12[k], e[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e16[6];
    logic [7:0] e12[6];
    bit done;
    for (int f = 0; f < 25; f++) begin
      got16.delete();
      got12.delete();
      di16 = 16'($urandom);
      du16 = 16'($urandom);
      di12 = 12'($urandom);
      du12 = 12'($urandom);
      model(int'(di16), int'(du16), e16);
      model(int'(di12), int'(du12), e12);
      done = 1'b0;
      for (int c = 0; c < 150; c++) begin
        @(posedge clk);
        #1;
        tx_ready = ($urandom_range(0, 3) != 0);
        word_clk = (c < 6);
        tick();
        if (c >= 8 && got16.size() >= 6 && got12.size() >= 6) begin
          done = 1'b1;
          break;
        end
      end
      word_clk = 1'b0;
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL rnd%0d_timeout got %0d/%0d bytes exp 6",
                 f, got16.size(), got12.size());
      end
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (got16[k] !== e16[k] || got12[k] !== e12[k]) begin
          fails++;
          $display("FAIL rnd%0d_byte%0d got %h/%h exp %h/%h",
                   f, k, got16[k], got12[k], e16[k], e12[k]);
        end
      end
    end
    tests++;
    if (o16 !== 1'b0 || o12 !== 1'b0) begin
      fails++;
      $display("FAIL rnd_overrun got %b/%b exp 0/0", o16, o12);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_reset_midframe();
    test_arm();
    test_width12();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_frame_packer.md
Name: sample_frame_packer

Overview:
- Sits between the two sinc3 decimation filters (I and U channels) and the byte-wide UART transmitter, all in the `clk` domain.
- On each `word_clk` rising edge it captures both filtered words and emits one fixed 6-byte frame over a valid/ready byte handshake: SYNC, I_hi, I_lo, U_hi, U_lo, CHK.
- This lets one UART carry both channels with framing and an integrity check.

Parameters:
- WIDTH, 16, filtered sample width. Legal range 9..16. Samples are zero-extended to 16 bits before splitting into bytes.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock (75 MHz).
- rst  input  1  asynchronous, active-high reset.
- word_clk  input  1  decimation strobe from the `mclkin` domain. Treated as asynchronous.
- data_i  input  WIDTH  filtered I-channel word. Stable for at least 4 `clk` cycles after `word_clk` rises.
- data_u  input  WIDTH  filtered U-channel word. Same stability rule as `data_i`.
- tx_ready  input  1  UART can accept a byte.
- tx_valid  output  1  `tx_data` holds a byte to send.
- tx_data  output  8  current frame byte.
- busy  output  1  frame in progress (state != IDLE).
- overrun  output  1  sticky flag: a sample was dropped.

Behaviour:
Reset:
- `rst` high asynchronously forces `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `overrun`=0, state=IDLE.
- Also clears the capture registers, the sync chain and the arm flag.
- Reset mid-frame abandons the frame at once. No partial completion after release.

Synchronisation and edge detection:
- `word_clk` passes through a 2-FF synchroniser, then a history register. An edge is `sync`=1 while `hist`=0.
- Arm flag: reset clears it. It is set the first cycle the synchronised `word_clk` is 0.
- Edges are ignored while unarmed. This prevents a spurious frame when `word_clk` is high at reset release.

Capture:
- Edge detected while state=IDLE → in that same cycle, latch `data_i` and `data_u` (zero-extended to 16 bits) and compute CHK = I_hi ^ I_lo ^ U_hi ^ U_lo.
- Next cycle: state=SYNC, `tx_valid`=1, `tx_data`=`SYNC_BYTE`.
- Latency from `word_clk` rise to first `tx_valid`: 3–4 `clk` cycles.

FSM:
- States, in order: IDLE → SYNC → IH → IL → UH → UL → CK → IDLE.
- In every non-IDLE state, `tx_valid`=1 and `tx_data` is the byte for that state.
- The state advances only on a clock edge where `tx_valid` && `tx_ready`.
- While `tx_ready`=0, `tx_data` and `tx_valid` stay stable. Never withdraw `tx_valid` once asserted.
- Accept in CK → next cycle IDLE, `tx_valid`=0, `tx_data` holds its last value.
- At most one frame every 7 cycles. Frame bytes are never re-sampled from the live inputs.

Overrun:
- Edge detected in any non-IDLE state, including the cycle in which CK is accepted → sample dropped, `overrun` set to 1.
- `overrun` stays set until `rst`. The frame in progress is unaffected.

Other boundary conditions:
- `tx_ready` high while state=IDLE → no effect.
- `busy` = (state != IDLE), registered with the state.

Test Plan:
1. WIDTH=16, `data_i`=16'h1234, `data_u`=16'hABCD, one `word_clk` pulse, `tx_ready`=1 → bytes A5,12,34,AB,CD,40 on 6 consecutive accepts; then `tx_valid`=0 and `busy`=0.
2. As test 1, but `tx_ready`=0 for 10 cycles once state=IH → `tx_valid`=1 and `tx_data`=12 held all 10 cycles; the remaining bytes follow in order after `tx_ready` returns high.
3. Second `word_clk` pulse while the UH byte is pending, `tx_ready`=0 → that frame completes with the original data, `overrun`=1, no second frame is produced.
4. Assert `rst` with `word_clk`=1, release, hold `word_clk` high for 20 cycles → no `tx_valid`. Drive `word_clk` 0 then 1 → exactly one frame.
5. WIDTH=12, `data_i`=12'hFFF, `data_u`=12'h800 → bytes A5,0F,FF,08,00,F8.
6. Assert `rst` asynchronously mid-cycle during UH → `tx_valid`=0, `tx_data`=00 and `overrun`=0 immediately. After release, no frame bytes appear until a new armed `word_clk` edge.
